// File: rtl/cory_arb4.sv
// Round-robin 4:1 valid/ready merge with optional packet lock. One registered output stage.
// Latency 1 cycle; requesters are stalled when the output register is full and i_z_r is low.
module cory_arb4 #(
  parameter int N    = 16,
  parameter bit LOCK = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_a0_v,
  input  logic [N-1:0] i_a0_d,
  input  logic         i_a0_l,
  output logic         o_a0_r,
  input  logic         i_a1_v,
  input  logic [N-1:0] i_a1_d,
  input  logic         i_a1_l,
  output logic         o_a1_r,
  input  logic         i_a2_v,
  input  logic [N-1:0] i_a2_d,
  input  logic         i_a2_l,
  output logic         o_a2_r,
  input  logic         i_a3_v,
  input  logic [N-1:0] i_a3_d,
  input  logic         i_a3_l,
  output logic         o_a3_r,
  output logic         o_z_v,
  output logic [N-1:0] o_z_d,
  output logic         o_z_l,
  output logic [1:0]   o_z_id,
  input  logic         i_z_r
);

  logic [3:0]   req_v;
  logic [3:0]   req_l;
  logic [N-1:0] req_d [4];

  assign req_v    = {i_a3_v, i_a2_v, i_a1_v, i_a0_v};
  assign req_l    = {i_a3_l, i_a2_l, i_a1_l, i_a0_l};
  assign req_d[0] = i_a0_d;
  assign req_d[1] = i_a1_d;
  assign req_d[2] = i_a2_d;
  assign req_d[3] = i_a3_d;

  logic         z_v_q,  z_v_d;
  logic [N-1:0] z_d_q,  z_d_d;
  logic         z_l_q,  z_l_d;
  logic [1:0]   z_id_q, z_id_d;
  logic [1:0]   ptr_q,  ptr_d;
  logic         lock_q, lock_d;
  logic [1:0]   held_q, held_d;

  logic       ld;
  logic       win_vld;
  logic [1:0] win;
  logic       win_last;
  logic [3:0] gnt;
  logic       acc;

  assign ld = ~z_v_q | i_z_r;

  // Descending scan so the requester closest to ptr is written last and wins.
  always_comb begin
    win_vld = 1'b0;
    win     = ptr_q;
    if (lock_q) begin
      win     = held_q;
      win_vld = req_v[held_q];
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (req_v[ptr_q + 2'(i)]) begin
          win_vld = 1'b1;
          win     = ptr_q + 2'(i);
        end
      end
    end
  end

  assign win_last = LOCK ? req_l[win] : 1'b1;

  always_comb begin
    gnt = 4'b0000;
    if (reset_n && ld && win_vld) begin
      gnt[win] = 1'b1;
    end
  end

  assign acc    = |gnt;
  assign o_a0_r = gnt[0];
  assign o_a1_r = gnt[1];
  assign o_a2_r = gnt[2];
  assign o_a3_r = gnt[3];

  always_comb begin
    z_v_d  = z_v_q;
    z_d_d  = z_d_q;
    z_l_d  = z_l_q;
    z_id_d = z_id_q;
    ptr_d  = ptr_q;
    lock_d = lock_q;
    held_d = held_q;
    if (acc) begin
      z_v_d  = 1'b1;
      z_d_d  = req_d[win];
      z_l_d  = win_last;
      z_id_d = win;
      if (win_last) begin
        ptr_d  = win + 2'd1;
        lock_d = 1'b0;
      end else begin
        lock_d = 1'b1;
        held_d = win;
      end
    end else if (ld) begin
      z_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      z_v_q  <= 1'b0;
      z_d_q  <= '0;
      z_l_q  <= 1'b0;
      z_id_q <= 2'd0;
      ptr_q  <= 2'd0;
      lock_q <= 1'b0;
      held_q <= 2'd0;
    end else begin
      z_v_q  <= z_v_d;
      z_d_q  <= z_d_d;
      z_l_q  <= z_l_d;
      z_id_q <= z_id_d;
      ptr_q  <= ptr_d;
      lock_q <= lock_d;
      held_q <= held_d;
    end
  end

  assign o_z_v  = z_v_q;
  assign o_z_d  = z_d_q;
  assign o_z_l  = z_l_q;
  assign o_z_id = z_id_q;

endmodule
